// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI burst controller.
// Holds the FSM state encoding and the parameter defaults.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_LOAD,
      ST_XFER,
      ST_CS_HOLD,
      ST_FINISH
   } state_e;

   localparam int CS_DLY_DEF    = 4;
   localparam int MAX_BYTES_DEF = 4;
   localparam int CNT_W         = 4;

endpackage

// File: rtl/spi_cs_timer.sv
// Chip-select guard timer: a load starts a CS_DLY-cycle window,
// and expired marks the last cycle of that window.
module spi_cs_timer
   import spi_pkg::*;
#(
   parameter int CS_DLY = CS_DLY_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic count_i,
   output logic expired_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_W'(CS_DLY - 1);
      end else if (count_i && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/spi_burst_ctrl.sv
// Multi-byte SPI burst sequencer driving a single-byte SPI master
// engine, with chip-select setup/hold guard intervals and abort.
module spi_burst_ctrl
   import spi_pkg::*;
#(
   parameter int CS_DLY    = CS_DLY_DEF,
   parameter int MAX_BYTES = MAX_BYTES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [1:0]  len,
   input  logic [31:0] tx_data,
   input  logic        cpol_i,
   input  logic        cpha_i,
   input  logic        abort,
   output logic [31:0] rx_data,
   output logic        busy,
   output logic        done,
   output logic        CS_n,
   output logic        m_start,
   output logic [7:0]  m_tx_data,
   input  logic [7:0]  m_rx_data,
   input  logic        m_done,
   input  logic        m_ready,
   output logic        CPOL,
   output logic        CPHA
);

   localparam int IW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
   localparam int BW = 8 * MAX_BYTES;

   state_e state_q;
   state_e state_d;

   logic [1:0]                 len_q;
   logic [MAX_BYTES-1:0][7:0]  tx_q;
   logic [MAX_BYTES-1:0][7:0]  rx_q;
   logic [IW-1:0]              idx_q;
   logic                       abort_q;
   logic                       cpol_q;
   logic                       cpha_q;
   logic [7:0]                 mtx_q;

   logic accept;
   logic abort_hit;
   logic last_byte;
   logic tmr_load;
   logic tmr_count;
   logic tmr_exp;

   assign accept    = (state_q == ST_IDLE) && req;
   assign abort_hit = abort_q || abort;
   assign last_byte = (idx_q == IW'(len_q));

   spi_cs_timer #(
      .CS_DLY (CS_DLY)
   ) u_cs_timer (
      .clk       (clk),
      .rst       (rst),
      .load_i    (tmr_load),
      .count_i   (tmr_count),
      .expired_o (tmr_exp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req) state_d = ST_CS_SETUP;
         end
         ST_CS_SETUP: begin
            if (abort_hit)    state_d = ST_CS_HOLD;
            else if (tmr_exp) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (abort_hit)    state_d = ST_CS_HOLD;
            else if (m_ready) state_d = ST_XFER;
         end
         ST_XFER: begin
            if (m_done) begin
               state_d = (last_byte || abort_hit) ? ST_CS_HOLD : ST_LOAD;
            end
         end
         ST_CS_HOLD: begin
            if (tmr_exp) state_d = ST_FINISH;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_FINISH);
      CS_n      = (state_q == ST_IDLE) || (state_q == ST_FINISH);
      m_start   = (state_q == ST_LOAD) && m_ready && !abort_hit;
      tmr_count = (state_q == ST_CS_SETUP) || (state_q == ST_CS_HOLD);
      tmr_load  = (state_d != state_q) &&
                  ((state_d == ST_CS_SETUP) || (state_d == ST_CS_HOLD));
   end

   // Burst context is captured only on accept, so a req while busy is inert.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         idx_q   <= '0;
         abort_q <= 1'b0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         mtx_q   <= '0;
      end else if (accept) begin
         len_q   <= len;
         tx_q    <= BW'(tx_data);
         rx_q    <= '0;
         idx_q   <= '0;
         abort_q <= 1'b0;
         cpol_q  <= cpol_i;
         cpha_q  <= cpha_i;
         mtx_q   <= tx_data[7:0];
      end else begin
         if (busy && abort) abort_q <= 1'b1;
         if (state_q == ST_XFER && m_done) begin
            rx_q[idx_q] <= m_rx_data;
            if (!(last_byte || abort_hit)) begin
               idx_q <= idx_q + 1'b1;
               mtx_q <= tx_q[idx_q + 1'b1];
            end
         end
      end
   end

   assign rx_data   = 32'(rx_q);
   assign m_tx_data = mtx_q;
   assign CPOL      = cpol_q;
   assign CPHA      = cpha_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Scoreboard bench for spi_burst_ctrl with a loopback byte-engine model.
// Expected burst results are queued at issue and checked on done.
module tb_spi_burst_ctrl;

   localparam int CSD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [1:0]  len;
   logic [31:0] tx_data;
   logic        cpol_i;
   logic        cpha_i;
   logic        abort;
   logic [31:0] rx_data;
   logic        busy;
   logic        done;
   logic        CS_n;
   logic        m_start;
   logic [7:0]  m_tx_data;
   logic [7:0]  m_rx_data;
   logic        m_done;
   logic        m_ready;
   logic        CPOL;
   logic        CPHA;

   always #5 clk = ~clk;

   spi_burst_ctrl #(
      .CS_DLY    (CSD),
      .MAX_BYTES (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .len       (len),
      .tx_data   (tx_data),
      .cpol_i    (cpol_i),
      .cpha_i    (cpha_i),
      .abort     (abort),
      .rx_data   (rx_data),
      .busy      (busy),
      .done      (done),
      .CS_n      (CS_n),
      .m_start   (m_start),
      .m_tx_data (m_tx_data),
      .m_rx_data (m_rx_data),
      .m_done    (m_done),
      .m_ready   (m_ready),
      .CPOL      (CPOL),
      .CPHA      (CPHA)
   );

   typedef struct {
      logic [31:0] rx;
      int          nstart;
      int          gap_lo;
      int          gap_hi;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Loopback byte engine: echoes the sent byte a few cycles after m_start.
   bit         hold_ready = 1'b0;
   int         eng_cnt = 0;
   logic [7:0] eng_byte;
   logic       st;
   logic [7:0] stx;

   initial begin
      m_done    = 1'b0;
      m_ready   = 1'b1;
      m_rx_data = '0;
      forever begin
         @(posedge clk);
         st  = m_start;
         stx = m_tx_data;
         @(negedge clk);
         m_done = 1'b0;
         if (st) begin
            eng_byte = stx;
            eng_cnt  = 3;
            m_ready  = 1'b0;
         end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               m_done    = 1'b1;
               m_rx_data = eng_byte;
               m_ready   = !hold_ready;
            end
         end else begin
            m_ready = !hold_ready;
         end
      end
   end

   // Monitor
   int          nstart = 0;
   int          falls = 0;
   int          mode_chg = 0;
   int          cs_low_cnt = 0;
   int          hold_cnt = 0;
   int          hold_gap = 0;
   int          gap = 0;
   int          done_seen = 0;
   logic [31:0] sent = '0;
   logic        cs_prev = 1'b1;
   logic        cpol_prev = 1'b0;
   logic        cpha_prev = 1'b0;
   logic        prev_done = 1'b0;
   exp_t        e;

   task automatic clear_burst();
      nstart     = 0;
      falls      = 0;
      mode_chg   = 0;
      cs_low_cnt = 0;
      hold_cnt   = 0;
      hold_gap   = 0;
      gap        = 0;
      sent       = '0;
   endtask

   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         clear_burst();
         cs_prev   = 1'b1;
         prev_done = 1'b0;
      end else begin
         if (prev_done) chk("busy_drop", 32'(busy), 32'd0);
         prev_done = done;
         if (!CS_n) begin
            if (cs_prev) falls++;
            if (!cs_prev && (CPOL !== cpol_prev || CPHA !== cpha_prev))
               mode_chg++;
            if (m_start) begin
               if (nstart == 0) gap = cs_low_cnt;
               sent = sent | (32'(m_tx_data) << (8 * nstart));
               nstart++;
            end
            if (m_done) hold_cnt = 0;
            else        hold_cnt++;
            cs_low_cnt++;
         end else if (!cs_prev) begin
            hold_gap = hold_cnt;
         end
         if (m_start && !m_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL start_no_ready: m_start=1 with m_ready=0");
         end
         cpol_prev = CPOL;
         cpha_prev = CPHA;
         cs_prev   = CS_n;
         if (done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: rx=%h", rx_data);
            end else begin
               e = sb_q.pop_front();
               chk("rx_data", rx_data, e.rx);
               chk("n_start", 32'(nstart), 32'(e.nstart));
               chk("sent_bytes", sent, e.rx);
               chk("cs_falls", 32'(falls), 32'd1);
               chk("mode_stable", 32'(mode_chg), 32'd0);
               chk("cs_hold", 32'(hold_gap), 32'(CSD));
               chk("cs_at_done", 32'(CS_n), 32'd1);
               chk("busy_at_done", 32'(busy), 32'd1);
               n_tests++;
               if (gap < e.gap_lo || gap > e.gap_hi) begin
                  n_fail++;
                  $display("FAIL cs_setup: got %0d expected %0d..%0d",
                           gap, e.gap_lo, e.gap_hi);
               end
            end
            clear_burst();
         end
      end
   end

   task automatic push(input logic [31:0] rx, input int n,
                       input int lo, input int hi);
      exp_t x;
      x.rx     = rx;
      x.nstart = n;
      x.gap_lo = lo;
      x.gap_hi = hi;
      sb_q.push_back(x);
   endtask

   task automatic start(input logic [1:0] l, input logic [31:0] d,
                        input logic cp, input logic ch, input logic ab);
      @(negedge clk);
      req     = 1'b1;
      len     = l;
      tx_data = d;
      cpol_i  = cp;
      cpha_i  = ch;
      abort   = ab;
      @(negedge clk);
      req   = 1'b0;
      abort = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int s = done_seen;
      int k = 0;
      while (done_seen == s && k < 400) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (done_seen == s) begin
         n_fail++;
         $display("FAIL %s: no done within %0d cycles", name, k);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_nstart(input int n);
      int k = 0;
      while (nstart < n && k < 200) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (nstart < n) begin
         n_fail++;
         $display("FAIL wait_start: got %0d starts expected %0d", nstart, n);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int d0;

   initial begin
      rst     = 1'b1;
      req     = 1'b0;
      len     = '0;
      tx_data = '0;
      cpol_i  = 1'b0;
      cpha_i  = 1'b0;
      abort   = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_cs_n", 32'(CS_n), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_m_start", 32'(m_start), 32'd0);
      chk("rst_rx", rx_data, 32'h0);
      chk("rst_m_tx", 32'(m_tx_data), 32'h0);
      chk("rst_cpol", 32'(CPOL), 32'd0);
      chk("rst_cpha", 32'(CPHA), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // mode 3, single byte
      push(32'h000000AA, 1, CSD, CSD);
      start(2'd0, 32'h000000AA, 1'b1, 1'b1, 1'b0);
      chk("accept_busy", 32'(busy), 32'd1);
      chk("accept_cs_n", 32'(CS_n), 32'd0);
      chk("accept_cpol", 32'(CPOL), 32'd1);
      chk("accept_cpha", 32'(CPHA), 32'd1);
      wait_done("single");
      chk("rx_hold1", rx_data, 32'h000000AA);

      // four bytes, mode 0
      push(32'hDEADBEEF, 4, CSD, CSD);
      start(2'd3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      wait_done("four");
      chk("rx_hold2", rx_data, 32'hDEADBEEF);

      // abort during byte 1
      push(32'h0000BEEF, 2, CSD, CSD);
      start(2'd3, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
      wait_nstart(2);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done("abort");

      // req while busy is ignored
      d0 = done_seen;
      push(32'h00001234, 2, CSD, CSD);
      start(2'd1, 32'h00001234, 1'b0, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      req     = 1'b1;
      len     = 2'd3;
      tx_data = 32'hFFFFFFFF;
      cpol_i  = 1'b1;
      repeat (2) @(negedge clk);
      req = 1'b0;
      wait_done("busy_req");
      repeat (20) @(negedge clk);
      chk("one_done", 32'(done_seen - d0), 32'd1);

      // reset mid byte 2
      start(2'd3, 32'hC0FFEE11, 1'b1, 1'b1, 1'b0);
      wait_nstart(3);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_cs_n", 32'(CS_n), 32'd1);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_m_start", 32'(m_start), 32'd0);
      chk("arst_rx", rx_data, 32'h0);
      chk("arst_cpol", 32'(CPOL), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      push(32'h00005A3C, 2, CSD, CSD);
      start(2'd1, 32'h00005A3C, 1'b0, 1'b0, 1'b0);
      wait_done("after_rst");

      // m_ready withheld in LOAD
      hold_ready = 1'b1;
      repeat (2) @(negedge clk);
      push(32'h0000003C, 1, CSD + 10, CSD + 40);
      start(2'd0, 32'h0000003C, 1'b0, 1'b1, 1'b0);
      repeat (CSD + 14) @(negedge clk);
      chk("ready_hold_nostart", 32'(nstart), 32'd0);
      hold_ready = 1'b0;
      wait_done("ready_hold");

      // req with abort in IDLE: abort ignored
      push(32'h00000F0F, 2, CSD, CSD);
      start(2'd1, 32'h00000F0F, 1'b1, 1'b0, 1'b1);
      wait_done("req_abort");

      repeat (10) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
